// File: rtl/mac_tile_simd.sv
// mac_tile_simd: SIMD dot-product MAC tile for a systolic array.
// Weight-stationary (WS) and output-stationary (OS) modes, saturating or
// wrapping accumulate, and a sticky overflow flag.

// One lane multiplier: both operands extended to psum_bw+1 bits so the
// product and the following adder tree never lose the true value.
module mac_tile_simd_lane #(
    parameter int bw     = 4,
    parameter int PW     = 16,
    parameter int SIGNED = 1
) (
    input  logic [bw-1:0] a,
    input  logic [bw-1:0] b,
    output logic [PW:0]   p
);
    logic [PW:0] ax, bx;

    assign ax = {{(PW+1-bw){SIGNED != 0 && a[bw-1]}}, a};
    assign bx = {{(PW+1-bw){SIGNED != 0 && b[bw-1]}}, b};
    assign p  = ax * bx;
endmodule

module mac_tile_simd #(
    parameter int bw      = 4,
    parameter int NLANE   = 2,
    parameter int psum_bw = 16,
    parameter int SIGNED  = 1,
    parameter int SAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NLANE*bw-1:0]   in_w,
    output logic [NLANE*bw-1:0]   out_e,
    input  logic [psum_bw-1:0]    in_n,
    output logic [psum_bw-1:0]    out_s,
    input  logic [2:0]            inst_w,
    output logic [2:0]            inst_e,
    input  logic                  ws_rearm,
    output logic                  ovf
);
    localparam int VW = NLANE * bw;
    localparam int PW = psum_bw;

    if (psum_bw < NLANE * bw) begin : g_bad_psum_bw
        $error("mac_tile_simd: psum_bw must be >= NLANE*bw");
    end

    typedef enum logic       {W_EMPTY, W_HELD}            wst_t;
    typedef enum logic [1:0] {OS_IDLE, OS_ACC, OS_DRAIN}  ost_t;

    wst_t wst, wst_d;
    ost_t ost, ost_d;

    logic [VW-1:0] a_q, b_q;
    logic [PW-1:0] c_q;
    logic [2:0]    inst_q, inst_d;

    logic [NLANE-1:0][PW:0] prod_ws, prod_os;
    logic [PW:0]   dot_ws, dot_os;
    logic [PW-1:0] ws_sum, os_sum, os_c_src;
    logic          ws_ov, os_ov;
    logic [PW:0]   b_ext;

    // Instruction decode: incoming (inst_w) and registered (inst_q)
    logic ws_in, os_exec_in, os_load_in, ws_take;
    logic ws_exec_q, os_exec_q, os_load_q;

    assign ws_in      = inst_w[2];
    assign os_exec_in = (inst_w == 3'b010);
    assign os_load_in = (inst_w == 3'b001);
    assign ws_exec_q  = inst_q[2] & inst_q[1];
    assign os_exec_q  = (inst_q == 3'b010);
    assign os_load_q  = (inst_q == 3'b001);
    // Weight capture only on a WS load into an empty tile; rearm wins
    assign ws_take    = !ws_rearm && (wst == W_EMPTY) && inst_w[2] && inst_w[0];

    // Accumulate with overflow detect; returns {ov, result}
    function automatic logic [PW:0] acc_f(input logic [PW-1:0] c, input logic [PW:0] d);
        logic [PW:0]   w;
        logic          ov;
        logic [PW-1:0] r;
        w  = {SIGNED != 0 && c[PW-1], c} + d;
        ov = (SIGNED != 0) ? (w[PW] ^ w[PW-1]) : w[PW];
        r  = w[PW-1:0];
        if (SAT != 0 && ov) begin
            if (SIGNED != 0) r = w[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
            else             r = '1;
        end
        return {ov, r};
    endfunction

    // WS lanes multiply held operands; OS lanes multiply the arriving ones
    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        mac_tile_simd_lane #(.bw(bw), .PW(PW), .SIGNED(SIGNED)) u_ws (
            .a(a_q[l*bw +: bw]), .b(b_q[l*bw +: bw]), .p(prod_ws[l]));
        mac_tile_simd_lane #(.bw(bw), .PW(PW), .SIGNED(SIGNED)) u_os (
            .a(in_w[l*bw +: bw]), .b(in_n[l*bw +: bw]), .p(prod_os[l]));
    end

    // Lane adder trees
    always_comb begin
        dot_ws = '0;
        dot_os = '0;
        for (int l = 0; l < NLANE; l++) begin
            dot_ws = dot_ws + prod_ws[l];
            dot_os = dot_os + prod_os[l];
        end
    end

    // First OS exec after idle/drain/mode change starts from zero
    assign os_c_src        = (ost == OS_ACC) ? c_q : '0;
    assign {ws_ov, ws_sum} = acc_f(c_q, dot_ws);
    assign {os_ov, os_sum} = acc_f(os_c_src, dot_os);

    // Next-state logic for weight and OS FSMs, plus forwarded instruction
    always_comb begin
        wst_d  = wst;
        ost_d  = ost;
        inst_d = inst_w;
        if (ws_rearm)     wst_d = W_EMPTY;
        else if (ws_take) wst_d = W_HELD;
        if (ws_in)           ost_d = OS_IDLE;
        else if (os_exec_in) ost_d = OS_ACC;
        else if (os_load_in) ost_d = OS_DRAIN;
        // A load landing in an empty WS tile is consumed here
        if (inst_w[2] && wst == W_EMPTY) inst_d[0] = 1'b0;
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wst <= W_EMPTY;
            ost <= OS_IDLE;
        end else begin
            wst <= wst_d;
            ost <= ost_d;
        end
    end

    // Operand, accumulator, instruction and sticky flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            inst_q <= '0;
            ovf    <= 1'b0;
        end else begin
            inst_q <= inst_d;
            ovf    <= ovf | (ws_exec_q & ws_ov) | (os_exec_in & os_ov);
            if (ws_in) begin
                c_q <= in_n;
                if (inst_w[1] | inst_w[0]) a_q <= in_w;
                if (ws_take)               b_q <= in_w;
            end else if (os_exec_in) begin
                a_q <= in_w;
                b_q <= in_n[VW-1:0];
                c_q <= os_sum;
            end else if (os_load_in && ost == OS_DRAIN) begin
                // Entry cycle presents own result; later cycles shift the chain
                c_q <= in_n;
            end
        end
    end

    // South output: WS psum, OS weight pass-through, or OS drain data
    assign b_ext = {{(PW+1-VW){SIGNED != 0 && b_q[VW-1]}}, b_q};
    always_comb begin
        out_s = '0;
        if (inst_q[2]) begin
            if (inst_q[1]) out_s = ws_sum;
        end else if (os_exec_q) begin
            out_s = b_ext[PW-1:0];
        end else if (os_load_q) begin
            out_s = c_q;
        end
    end

    assign out_e  = a_q;
    assign inst_e = inst_q;
endmodule

// File: tb/tb_mac_tile_simd.sv
// Directed self-checking bench for mac_tile_simd (bw=4, NLANE=2, psum_bw=16,
// SIGNED=1, SAT=1).
module tb_mac_tile_simd;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_w;
    logic [7:0]  out_e;
    logic [15:0] in_n;
    logic [15:0] out_s;
    logic [2:0]  inst_w;
    logic [2:0]  inst_e;
    logic        ws_rearm;
    logic        ovf;

    int nchecks = 0;
    int nerr    = 0;

    mac_tile_simd #(.bw(4), .NLANE(2), .psum_bw(16), .SIGNED(1), .SAT(1)) dut (
        .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e), .in_n(in_n),
        .out_s(out_s), .inst_w(inst_w), .inst_e(inst_e), .ws_rearm(ws_rearm),
        .ovf(ovf));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, ".out_s"},  out_s,           16'h0000);
        chk({tag, ".out_e"},  {8'h0, out_e},   16'h0000);
        chk({tag, ".inst_e"}, {13'h0, inst_e}, 16'h0000);
        chk({tag, ".ovf"},    {15'h0, ovf},    16'h0000);
    endtask

    initial begin
        // 1: reset with busy-looking inputs
        reset = 1'b1; in_w = 8'hFF; inst_w = 3'b110; in_n = 16'h0; ws_rearm = 1'b0;
        tick(); chk_idle0("rst_c1");
        tick(); chk_idle0("rst_c2");
        reset = 1'b0; in_w = 8'h00; inst_w = 3'b000;
        #1; chk_idle0("rst_release");
        tick(); chk_idle0("post_rst_nop");

        // 2: WS first load captured, second load ripples east
        inst_w = 3'b101; in_w = 8'h32; in_n = 16'h0;
        tick();
        chk("ws_ld1.inst_e", {13'h0, inst_e}, 16'h0004);
        chk("ws_ld1.out_e",  {8'h0, out_e},   16'h0032);
        chk("ws_ld1.out_s",  out_s,           16'h0000);
        inst_w = 3'b101; in_w = 8'h55;
        tick();
        chk("ws_ld2.inst_e", {13'h0, inst_e}, 16'h0005);
        chk("ws_ld2.out_e",  {8'h0, out_e},   16'h0055);
        chk("ws_ld2.b_q",    {8'h0, dut.b_q}, 16'h0032);
        inst_w = 3'b110; in_w = 8'h11; in_n = 16'd10;
        tick();
        chk("ws_exec.out_s",  out_s,           16'd15);
        chk("ws_exec.inst_e", {13'h0, inst_e}, 16'h0006);

        // 3: OS accumulate, weight flows south
        inst_w = 3'b010; in_w = 8'h21; in_n = 16'h0013;
        tick();
        chk("os1.c_q",   dut.c_q,       16'd5);
        chk("os1.out_s", out_s,         16'h0013);
        chk("os1.out_e", {8'h0, out_e}, 16'h0021);
        tick(); chk("os2.c_q", dut.c_q, 16'd10);
        tick();
        chk("os3.c_q",   dut.c_q, 16'd15);
        chk("os3.out_s", out_s,   16'h0013);

        // 4: drain, own result first, then shifted-in data; then auto-clear
        inst_w = 3'b001; in_n = 16'h0042;
        tick();
        chk("drain1.out_s",  out_s,           16'd15);
        chk("drain1.inst_e", {13'h0, inst_e}, 16'h0001);
        tick(); chk("drain2.out_s", out_s, 16'h0042);
        inst_w = 3'b010; in_w = 8'h21; in_n = 16'h0013;
        tick();
        chk("os_clr.c_q",   dut.c_q, 16'd5);
        chk("os_clr.out_s", out_s,   16'h0013);

        // 5: re-arm, load (7,7), saturating exec, sticky flag
        inst_w = 3'b100; ws_rearm = 1'b1; in_n = 16'h0;
        tick(); chk("rearm.out_s", out_s, 16'h0000);
        ws_rearm = 1'b0; inst_w = 3'b101; in_w = 8'h77;
        tick(); chk("ld77.inst_e", {13'h0, inst_e}, 16'h0004);
        inst_w = 3'b110; in_w = 8'h77; in_n = 16'd32760;
        tick(); chk("sat.out_s", out_s, 16'h7FFF);
        inst_w = 3'b100; in_n = 16'h0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk($sformatf("ovf_sticky%0d", i), {15'h0, ovf}, 16'h0001);
        end

        // 6: signed negative operands
        inst_w = 3'b110; in_w = 8'h88; in_n = 16'h0;
        tick(); chk("signed.out_s", out_s, 16'hFF90);
        // load with rearm in the same cycle: rearm wins, no capture
        ws_rearm = 1'b1; inst_w = 3'b101; in_w = 8'h11;
        tick();
        chk("rearm_ld.b_q",    {8'h0, dut.b_q}, 16'h0077);
        chk("rearm_ld.inst_e", {13'h0, inst_e}, 16'h0005);
        ws_rearm = 1'b0;
        tick();
        chk("reload.b_q",    {8'h0, dut.b_q}, 16'h0011);
        chk("reload.inst_e", {13'h0, inst_e}, 16'h0004);
        inst_w = 3'b110; in_w = 8'h11; in_n = 16'h0;
        tick(); chk("reload_exec.out_s", out_s, 16'd2);

        // Reset clears the sticky flag
        reset = 1'b1; inst_w = 3'b000; in_w = 8'h00;
        tick(); chk_idle0("final_rst");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
